// File: rtl/amplitude_arbiter_if.sv
// amplitude_arbiter_if
//   Bundles the request side, the engine side and the result side of the
//   amplitude arbiter into one interface.
//   slave  : the arbiter's view. It receives requests and the engine result.
//            It drives ready, the engine operands and the tagged result.
//   master : the environment's view. It drives requests and the engine result.
//            It observes ready, the engine operands and the tagged result.
//   Signals:
//     req_valid / req_ready         per-channel handshake, ch0 in bit 0
//     req_data_i / req_data_q       packed per-channel I/Q samples, ch0 in the LSBs
//     eng_data_i / eng_data_q       operands presented to the amplitude engine
//     eng_result                    engine amplitude output
//     out_valid / out_ch / out_data tagged result strobe
interface amplitude_arbiter_if #(
  parameter int NUM_CH    = 4,
  parameter int SIZE_DATA = 16
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]           req_valid;
  logic [NUM_CH-1:0]           req_ready;
  logic [NUM_CH*SIZE_DATA-1:0] req_data_i;
  logic [NUM_CH*SIZE_DATA-1:0] req_data_q;
  logic [SIZE_DATA-1:0]        eng_data_i;
  logic [SIZE_DATA-1:0]        eng_data_q;
  logic [SIZE_DATA-1:0]        eng_result;
  logic                        out_valid;
  logic [CH_W-1:0]             out_ch;
  logic [SIZE_DATA-1:0]        out_data;

  modport slave (
    input  req_valid, req_data_i, req_data_q, eng_result,
    output req_ready, eng_data_i, eng_data_q, out_valid, out_ch, out_data
  );

  modport master (
    output req_valid, req_data_i, req_data_q, eng_result,
    input  req_ready, eng_data_i, eng_data_q, out_valid, out_ch, out_data
  );
endinterface

// File: rtl/amplitude_arbiter.sv
// amplitude_arbiter
//   Time-shares one fixed-latency amplitude engine among NUM_CH I/Q
//   requesters. Grants are round-robin, and at most one sample is issued per
//   cycle. A {valid, ch} tag travels alongside the sample through a delay line
//   matched to the engine latency. Each engine result is then reported with
//   its channel id.
//   Ports:
//     clk        clock, all logic on posedge
//     reset      synchronous, active-high
//     enable     1 = grants allowed; 0 = no new grants, in-flight samples drain
//     bus        amplitude_arbiter_if.slave (request / engine / result signals)
//     idle       1 when no sample is in flight and out_valid is low
//     grant_cnt  per-channel saturating grant counters, CNT_W bits each,
//                present only when the macro AMP_ARB_STATS_EN is defined
//   Optional feature macro: AMP_ARB_STATS_EN
module amplitude_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int SIZE_DATA   = 16,
  parameter int ENG_LATENCY = 6,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  amplitude_arbiter_if.slave        bus,
  output logic                      idle
`ifdef AMP_ARB_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]   grant_cnt
`endif
);
  localparam int              CH_W     = $clog2(NUM_CH);
  localparam logic [CH_W:0]   NUM_CH_W = NUM_CH[CH_W:0];
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  if (NUM_CH < 2 || NUM_CH > 16 || ENG_LATENCY < 1 || CNT_W < 1) begin : g_bad_params
    $error("amplitude_arbiter: parameter out of range");
  end

  logic [CH_W-1:0]      ptr_r;
  logic [NUM_CH-1:0]    pick_s;
  logic [CH_W-1:0]      pick_ch_s;
  logic                 pick_any_s;
  logic [CH_W:0]        idx_s;
  logic [NUM_CH-1:0]    grant_s;
  logic                 transfer_s;
  logic                 busy_next_s;

  logic [SIZE_DATA-1:0] eng_i_r;
  logic [SIZE_DATA-1:0] eng_q_r;
  // The issue tag sits beside the engine operand registers. The tag line
  // behind it then spans exactly the engine latency. As a result, the last
  // tag stage and the matching eng_result appear in the same cycle.
  logic                 iss_vld_r;
  logic [CH_W-1:0]      iss_ch_r;
  logic                 tag_vld_r [ENG_LATENCY];
  logic [CH_W-1:0]      tag_ch_r  [ENG_LATENCY];

  logic                 out_valid_r;
  logic [CH_W-1:0]      out_ch_r;
  logic [SIZE_DATA-1:0] out_data_r;
  logic                 idle_r;

  // Rotating-priority search: first valid channel at or above the pointer, wrapping.
  always_comb begin
    pick_s     = '0;
    pick_ch_s  = '0;
    pick_any_s = 1'b0;
    idx_s      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_s = {1'b0, ptr_r} + i[CH_W:0];
      if (idx_s >= NUM_CH_W) begin
        idx_s = idx_s - NUM_CH_W;
      end else begin
        idx_s = idx_s;
      end
      if (!pick_any_s && bus.req_valid[idx_s[CH_W-1:0]]) begin
        pick_any_s                = 1'b1;
        pick_ch_s                 = idx_s[CH_W-1:0];
        pick_s[idx_s[CH_W-1:0]]   = 1'b1;
      end else begin
        pick_any_s = pick_any_s;
      end
    end
  end

  // Grants are suppressed while disabled or in reset; a pick is only a transfer when granted.
  always_comb begin
    if (enable && !reset && pick_any_s) begin
      grant_s    = pick_s;
      transfer_s = 1'b1;
    end else begin
      grant_s    = '0;
      transfer_s = 1'b0;
    end
  end

  // Anything that will still be in flight or reporting after the next edge.
  always_comb begin
    busy_next_s = transfer_s | iss_vld_r;
    for (int s = 0; s < ENG_LATENCY; s++) begin
      busy_next_s = busy_next_s | tag_vld_r[s];
    end
  end

  // Pointer, engine operands, tag line, result capture and idle flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r       <= '0;
      eng_i_r     <= '0;
      eng_q_r     <= '0;
      iss_vld_r   <= 1'b0;
      iss_ch_r    <= '0;
      for (int s = 0; s < ENG_LATENCY; s++) begin
        tag_vld_r[s] <= 1'b0;
        tag_ch_r[s]  <= '0;
      end
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      out_data_r  <= '0;
      idle_r      <= 1'b1;
    end else begin
      if (transfer_s) begin
        ptr_r   <= (pick_ch_s == LAST_CH) ? {CH_W{1'b0}} : pick_ch_s + 1'b1;
        eng_i_r <= bus.req_data_i[pick_ch_s*SIZE_DATA +: SIZE_DATA];
        eng_q_r <= bus.req_data_q[pick_ch_s*SIZE_DATA +: SIZE_DATA];
      end else begin
        // Idle issue slots feed the engine zeros.
        ptr_r   <= ptr_r;
        eng_i_r <= '0;
        eng_q_r <= '0;
      end
      iss_vld_r    <= transfer_s;
      iss_ch_r     <= pick_ch_s;
      tag_vld_r[0] <= iss_vld_r;
      tag_ch_r[0]  <= iss_ch_r;
      for (int s = 1; s < ENG_LATENCY; s++) begin
        tag_vld_r[s] <= tag_vld_r[s-1];
        tag_ch_r[s]  <= tag_ch_r[s-1];
      end
      if (tag_vld_r[ENG_LATENCY-1]) begin
        out_valid_r <= 1'b1;
        out_ch_r    <= tag_ch_r[ENG_LATENCY-1];
        out_data_r  <= bus.eng_result;
      end else begin
        out_valid_r <= 1'b0;
        out_ch_r    <= out_ch_r;
        out_data_r  <= out_data_r;
      end
      idle_r <= ~busy_next_s;
    end
  end

  assign bus.req_ready  = grant_s;
  assign bus.eng_data_i = eng_i_r;
  assign bus.eng_data_q = eng_q_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_ch     = out_ch_r;
  assign bus.out_data   = out_data_r;
  assign idle           = idle_r;

`ifdef AMP_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_r [NUM_CH];

  // Per-channel grant counters that stick at all-ones; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (grant_s[k] && (cnt_r[k] != {CNT_W{1'b1}})) begin
          cnt_r[k] <= cnt_r[k] + 1'b1;
        end else begin
          cnt_r[k] <= cnt_r[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt_out
    assign grant_cnt[k*CNT_W +: CNT_W] = cnt_r[k];
  end
`endif
endmodule

// File: tb/tb_amplitude_arbiter.sv
`timescale 1ns/1ps
module tb_amplitude_arbiter;
  localparam int NUM_CH    = 4;
  localparam int SIZE_DATA = 16;
  localparam int L         = 6;
  localparam int CNT_W     = 4;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b1;
  logic idle;
`ifdef AMP_ARB_STATS_EN
  logic [NUM_CH*CNT_W-1:0] grant_cnt;
`endif

  amplitude_arbiter_if #(.NUM_CH(NUM_CH), .SIZE_DATA(SIZE_DATA)) bus ();

  amplitude_arbiter #(
    .NUM_CH(NUM_CH), .SIZE_DATA(SIZE_DATA), .ENG_LATENCY(L), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bus(bus),
    .idle(idle)
`ifdef AMP_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Integer magnitude: floor(sqrt(i^2+q^2)).
  function automatic logic [SIZE_DATA-1:0] amp(input logic [SIZE_DATA-1:0] i, input logic [SIZE_DATA-1:0] q);
    longint s;
    longint r;
    s = longint'(i) * longint'(i) + longint'(q) * longint'(q);
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return SIZE_DATA'(r);
  endfunction

  // Engine model: result reflects operands ENG_LATENCY edges after they change.
  logic [SIZE_DATA-1:0] eng_pipe [L];
  always @(posedge clk) begin
    eng_pipe[0] <= amp(bus.eng_data_i, bus.eng_data_q);
    for (int i = 1; i < L; i++) eng_pipe[i] <= eng_pipe[i-1];
  end
  assign bus.eng_result = eng_pipe[L-1];

  // Reference model: own round-robin pointer plus a queue of timestamped results.
  typedef struct {
    int                   due;
    int                   ch;
    logic [SIZE_DATA-1:0] val;
  } exp_t;
  exp_t                 expq[$];
  int                   cyc = 0;
  int                   model_ptr = 0;
  bit                   model_on = 1'b0;
  logic [SIZE_DATA-1:0] exp_ch = '0, exp_data = '0, exp_eng_i = '0, exp_eng_q = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [NUM_CH-1:0] exp_ready;
    bit                exp_valid;
    int                g;
    if (model_on) begin
      exp_valid = (expq.size() > 0) && (expq[0].due == cyc);
      check("m_out_valid", bus.out_valid, exp_valid);
      check("m_idle", idle, expq.size() == 0);
      if (exp_valid) begin
        exp_ch   = SIZE_DATA'(expq[0].ch);
        exp_data = expq[0].val;
        void'(expq.pop_front());
      end
      check("m_out_ch", bus.out_ch, exp_ch);
      check("m_out_data", bus.out_data, exp_data);
      check("m_eng_i", bus.eng_data_i, exp_eng_i);
      check("m_eng_q", bus.eng_data_q, exp_eng_q);
      exp_ready = '0;
      g = -1;
      if (enable && !reset) begin
        for (int k = 0; k < NUM_CH; k++) begin
          int c;
          c = (model_ptr + k) % NUM_CH;
          if (g < 0 && bus.req_valid[c]) g = c;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check("m_req_ready", bus.req_ready, exp_ready);
      check("m_onehot", $countones(bus.req_ready) <= 1, 1);
      if (!reset && g >= 0) begin
        exp_eng_i = bus.req_data_i[g*SIZE_DATA +: SIZE_DATA];
        exp_eng_q = bus.req_data_q[g*SIZE_DATA +: SIZE_DATA];
        expq.push_back('{due: cyc + 1 + L + 1, ch: g, val: amp(exp_eng_i, exp_eng_q)});
        model_ptr = (g + 1) % NUM_CH;
      end else begin
        exp_eng_i = '0;
        exp_eng_q = '0;
      end
    end
    if (reset) begin
      expq.delete();
      model_ptr = 0;
      exp_ch    = '0;
      exp_data  = '0;
      exp_eng_i = '0;
      exp_eng_q = '0;
      model_on  = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [SIZE_DATA-1:0] i, input logic [SIZE_DATA-1:0] q);
    bus.req_data_i[ch*SIZE_DATA +: SIZE_DATA] = i;
    bus.req_data_q[ch*SIZE_DATA +: SIZE_DATA] = q;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int          pulses;
    bit          seen;
    bit          prev;
    logic [3:0]  seq [4];
    bus.req_valid  = '0;
    bus.req_data_i = '0;
    bus.req_data_q = '0;
    step();
    step();
    reset = 1'b0;
    check("reset_idle", idle, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);

    // 1: single ch1 request (3,4) -> 5 after 7 edges
    set_ch(1, 16'd3, 16'd4);
    bus.req_valid = 4'b0010;
    #1 check("t1_ready", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = 4'b0000;
    repeat (6) step();
    check("t1_not_early", bus.out_valid, 0);
    step();
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_out_ch", bus.out_ch, 1);
    check("t1_out_data", bus.out_data, 5);
    repeat (2) step();
    check("t1_idle", idle, 1);

    // 2: all channels held valid for 12 cycles
    do_reset();
    set_ch(0, 16'd3, 16'd4);
    set_ch(1, 16'd6, 16'd8);
    set_ch(2, 16'd5, 16'd12);
    set_ch(3, 16'd8, 16'd15);
    bus.req_valid = 4'b1111;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      #1 check("t2_rr_order", bus.req_ready, 4'b0001 << (i % 4));
      step();
      if (bus.out_valid) pulses++;
    end
    bus.req_valid = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_valid) pulses++;
    end
    check("t2_pulses", pulses, 12);
    check("t2_last_ch", bus.out_ch, 3);
    check("t2_last_data", bus.out_data, 17);

    // 3: ch2 alone, then ch0 joins -> 0,2,0,2
    do_reset();
    bus.req_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_ch2_only", bus.req_ready, 4'b0100);
      step();
    end
    bus.req_valid = 4'b0101;
    seq[0] = 4'b0001; seq[1] = 4'b0100; seq[2] = 4'b0001; seq[3] = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      #1 check("t3_alternate", bus.req_ready, seq[i]);
      step();
    end
    bus.req_valid = 4'b0000;
    repeat (10) step();

    // 4: three in flight, then enable drops
    do_reset();
    bus.req_valid = 4'b1110;
    for (int i = 0; i < 3; i++) step();
    enable = 1'b0;
    pulses = 0;
    seen   = 1'b0;
    prev   = 1'b0;
    for (int t = 0; t < 15; t++) begin
      #1 check("t4_ready_off", bus.req_ready, 4'b0000);
      if (bus.out_valid) pulses++;
      if (prev && !bus.out_valid && !seen) begin
        check("t4_idle_rise", idle, 1);
        seen = 1'b1;
      end
      prev = bus.out_valid;
      step();
    end
    check("t4_results", pulses, 3);
    check("t4_idle_seen", seen, 1);
    bus.req_valid = 4'b0000;
    enable = 1'b1;
    step();

    // 5: reset with four samples in flight, pointer at ch2
    do_reset();
    bus.req_valid = 4'b0011;
    repeat (4) step();
    reset = 1'b1;
    #1 check("t5_ready_in_reset", bus.req_ready, 4'b0000);
    step();
    reset = 1'b0;
    bus.req_valid = 4'b0000;
    check("t5_out_valid", bus.out_valid, 0);
    check("t5_out_ch", bus.out_ch, 0);
    check("t5_out_data", bus.out_data, 0);
    check("t5_idle", idle, 1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_valid) pulses++;
    end
    check("t5_no_stale", pulses, 0);
    bus.req_valid = 4'b1111;
    #1 check("t5_ptr_restart", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = 4'b0000;
    repeat (10) step();

    // 6: twenty grants to ch3
    do_reset();
    set_ch(3, 16'd8, 16'd15);
    bus.req_valid = 4'b1000;
    repeat (20) step();
    bus.req_valid = 4'b0000;
    repeat (10) step();
    check("t6_out_ch", bus.out_ch, 3);
    check("t6_out_data", bus.out_data, 17);
`ifdef AMP_ARB_STATS_EN
    check("t6_cnt3", grant_cnt[3*CNT_W +: CNT_W], 15);
    for (int k = 0; k < 3; k++) check("t6_cnt_other", grant_cnt[k*CNT_W +: CNT_W], 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
